// File: rtl/rs_enc_lfsr.sv
// Systematic RS(K+4,K) encoder over GF(2^8) (poly 0x11D), valid/ready streaming.
// Optional define RS_ENC_ERR_INJ_EN adds inj_mask, XORed into each symbol loaded into out_data.
module rs_enc_lfsr #(
    parameter int unsigned K = 251
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop
`ifdef RS_ENC_ERR_INJ_EN
    ,
    input  logic [7:0] inj_mask
`endif
);

    typedef enum logic [1:0] {StIdle, StMsg, StPar} state_e;

    localparam logic [7:0] KCnt = 8'(K);

    state_e          r_state, w_state_d;
    logic [7:0]      r_cnt, w_cnt_d, w_cnt_inc;
    logic [3:0][7:0] r_p, w_p_d;
    logic [7:0]      r_out_data, w_data_d;
    logic            r_out_valid, w_valid_d;
    logic            r_out_sop, w_sop_d;
    logic            r_out_eop, w_eop_d;
    logic            w_adv, w_acc;
    logic [7:0]      w_fb, w_mask;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

`ifdef RS_ENC_ERR_INJ_EN
    assign w_mask = inj_mask;
`else
    assign w_mask = 8'h00;
`endif

    assign w_adv     = !r_out_valid || out_ready;
    assign in_ready  = ((r_state == StIdle) || (r_state == StMsg)) && w_adv;
    assign w_acc     = in_valid && in_ready;
    assign w_fb      = in_data ^ r_p[3];
    assign w_cnt_inc = r_cnt + 8'd1;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_p_d     = r_p;
        w_data_d  = r_out_data;
        w_valid_d = r_out_valid;
        w_sop_d   = r_out_sop;
        w_eop_d   = r_out_eop;
        unique case (r_state)
            StIdle, StMsg: begin
                if (w_acc) begin
                    w_data_d  = in_data ^ w_mask;
                    w_valid_d = 1'b1;
                    w_sop_d   = (r_state == StIdle);
                    w_eop_d   = 1'b0;
                    // LFSR always sees the clean symbol
                    w_p_d[3]  = r_p[2] ^ gf_mul(w_fb, 8'h0F);
                    w_p_d[2]  = r_p[1] ^ gf_mul(w_fb, 8'h36);
                    w_p_d[1]  = r_p[0] ^ gf_mul(w_fb, 8'h78);
                    w_p_d[0]  = gf_mul(w_fb, 8'h40);
                    if (w_cnt_inc == KCnt) begin
                        w_state_d = StPar;
                        w_cnt_d   = 8'd0;
                    end else begin
                        w_state_d = StMsg;
                        w_cnt_d   = w_cnt_inc;
                    end
                end else if (w_adv) begin
                    w_valid_d = 1'b0;
                    w_sop_d   = 1'b0;
                    w_eop_d   = 1'b0;
                end
            end
            StPar: begin
                if (w_adv) begin
                    w_data_d  = r_p[3] ^ w_mask;
                    w_valid_d = 1'b1;
                    w_sop_d   = 1'b0;
                    w_p_d     = {r_p[2], r_p[1], r_p[0], 8'h00};
                    if (r_cnt == 8'd3) begin
                        w_eop_d   = 1'b1;
                        w_state_d = StIdle;
                        w_cnt_d   = 8'd0;
                    end else begin
                        w_eop_d   = 1'b0;
                        w_cnt_d   = w_cnt_inc;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_cnt       <= 8'd0;
            r_p         <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_p         <= w_p_d;
            r_out_data  <= w_data_d;
            r_out_valid <= w_valid_d;
            r_out_sop   <= w_sop_d;
            r_out_eop   <= w_eop_d;
        end
    end

endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Directed bench for rs_enc_lfsr: a K=4 instance for codeword scenarios and a K=251 instance.
module tb_rs_enc_lfsr;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sop, a_out_eop;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sop, b_out_eop;
    logic [7:0] b_in_data, b_out_data;
`ifdef RS_ENC_ERR_INJ_EN
    logic [7:0] a_inj, b_inj;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q_data[$];
    logic       q_sop[$];
    logic       q_eop[$];
    logic [7:0] msg[4];
    logic [7:0] e2[8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    bit         inj_on = 1'b0;
    int         base;

    int b_cnt = 0, b_nonzero = 0, b_sop_cnt = 0, b_eop_cnt = 0;
    bit b_sop_first = 1'b0, b_eop_last = 1'b0;

    rs_enc_lfsr #(.K(4)) u_a (
        .clk(clk), .rstn(rstn), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_sop(a_out_sop), .out_eop(a_out_eop)
`ifdef RS_ENC_ERR_INJ_EN
        , .inj_mask(a_inj)
`endif
    );

    rs_enc_lfsr #(.K(251)) u_b (
        .clk(clk), .rstn(rstn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_sop(b_out_sop), .out_eop(b_out_eop)
`ifdef RS_ENC_ERR_INJ_EN
        , .inj_mask(b_inj)
`endif
    );

    always @(posedge clk) begin
        if (rstn && a_out_valid && a_out_ready) begin
            q_data.push_back(a_out_data);
            q_sop.push_back(a_out_sop);
            q_eop.push_back(a_out_eop);
        end
    end

    always @(posedge clk) begin
        if (rstn && b_out_valid && b_out_ready) begin
            if (b_out_data != 8'h00) b_nonzero++;
            if (b_out_sop) begin
                b_sop_cnt++;
                if (b_cnt == 0) b_sop_first = 1'b1;
            end
            if (b_out_eop) begin
                b_eop_cnt++;
                if (b_cnt == 254) b_eop_last = 1'b1;
            end
            b_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Horner evaluation of the captured 8-symbol codeword at root
    function automatic logic [7:0] synd(input int b0, input logic [7:0] root);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++) s = gf_mul(s, root) ^ q_data[b0 + i];
        return s;
    endfunction

    task automatic run_a(input int nsym, input int nexp, input bit stall);
        int sent = 0;
        int got0 = q_data.size();
        int cyc  = 0;
        bit done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            a_out_ready = stall ? ~cyc[0] : 1'b1;
            a_in_valid  = (sent < nsym);
            a_in_data   = (sent < nsym) ? msg[sent] : 8'h00;
`ifdef RS_ENC_ERR_INJ_EN
            a_inj       = (inj_on && sent == 2 && sent < nsym) ? 8'h5A : 8'h00;
`endif
            #1;
            if (a_out_valid && !a_out_ready) chk("stall_in_ready", 32'(a_in_ready), 32'd0);
            if (a_in_valid && a_in_ready) sent++;
            if (q_data.size() - got0 >= nexp) done = 1'b1;
            cyc++;
        end
        chk("collected", 32'(q_data.size() - got0), 32'(nexp));
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
    endtask

    task automatic check_e2(input string tag, input int b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 32'(q_data[b0 + i]), 32'(e2[i]));
            chk($sformatf("%s_sop%0d", tag, i), 32'(q_sop[b0 + i]), 32'(i == 0));
            chk($sformatf("%s_eop%0d", tag, i), 32'(q_eop[b0 + i]), 32'(i == 7));
        end
    endtask

    initial begin
        rstn        = 1'b0;
        a_in_valid  = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b1;
        b_in_valid  = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
`ifdef RS_ENC_ERR_INJ_EN
        a_inj = 8'h00; b_inj = 8'h00;
`endif
        #12;
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_data",  32'(a_out_data),  32'd0);
        chk("rst_a_sop",   32'(a_out_sop),   32'd0);
        chk("rst_a_eop",   32'(a_out_eop),   32'd0);
        chk("rst_a_ready", 32'(a_in_ready),  32'd1);
        chk("rst_b_valid", 32'(b_out_valid), 32'd0);
        chk("rst_b_ready", 32'(b_in_ready),  32'd1);
        @(negedge clk);
        rstn = 1'b1;

        // K=4, message 00 00 00 01 -> parity equals the generator's low coefficients
        msg  = '{8'h00, 8'h00, 8'h00, 8'h01};
        base = q_data.size();
        run_a(4, 8, 1'b0);
        check_e2("s2", base);

        // K=4, 01 02 03 04: message passes through and all four syndromes vanish
        msg  = '{8'h01, 8'h02, 8'h03, 8'h04};
        base = q_data.size();
        run_a(4, 8, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("s3_msg%0d", i), 32'(q_data[base + i]), 32'(msg[i]));
        chk("s3_syn0", 32'(synd(base, 8'h01)), 32'd0);
        chk("s3_syn1", 32'(synd(base, 8'h02)), 32'd0);
        chk("s3_syn2", 32'(synd(base, 8'h04)), 32'd0);
        chk("s3_syn3", 32'(synd(base, 8'h08)), 32'd0);

        // out_ready toggling 1-0-1-0 must not change the symbol sequence
        msg  = '{8'h00, 8'h00, 8'h00, 8'h01};
        base = q_data.size();
        run_a(4, 8, 1'b1);
        check_e2("s4", base);
        chk("s4_no_extra", 32'(q_data.size() - base), 32'd8);

        // reset after two message symbols, then a fresh codeword
        msg = '{8'h05, 8'h06, 8'h00, 8'h00};
        run_a(2, 1, 1'b0);
        chk("s5_pre_valid", 32'(a_out_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(a_out_valid), 32'd0);
        chk("s5_rst_data",  32'(a_out_data),  32'd0);
        chk("s5_rst_ready", 32'(a_in_ready),  32'd1);
        @(negedge clk);
        rstn = 1'b1;
        msg  = '{8'h00, 8'h00, 8'h00, 8'h01};
        base = q_data.size();
        run_a(4, 8, 1'b0);
        check_e2("s5", base);

`ifdef RS_ENC_ERR_INJ_EN
        // mask on message symbol 2 only; parity comes from the clean data
        inj_on = 1'b1;
        base   = q_data.size();
        run_a(4, 8, 1'b0);
        inj_on = 1'b0;
        for (int i = 0; i < 8; i++)
            chk($sformatf("inj_data%0d", i), 32'(q_data[base + i]),
                32'(i == 2 ? (e2[i] ^ 8'h5A) : e2[i]));
`endif

        // K=251 all-zero message with out_ready held high
        begin
            int sent = 0;
            for (int c = 0; c < 400 && b_cnt < 255; c++) begin
                @(negedge clk);
                b_in_valid = (sent < 251);
                b_in_data  = 8'h00;
                #1;
                if (b_in_valid && b_in_ready) sent++;
            end
            b_in_valid = 1'b0;
            chk("k251_sent", 32'(sent), 32'd251);
        end
        chk("k251_count",     32'(b_cnt),       32'd255);
        chk("k251_nonzero",   32'(b_nonzero),   32'd0);
        chk("k251_sop_first", 32'(b_sop_first), 32'd1);
        chk("k251_sop_cnt",   32'(b_sop_cnt),   32'd1);
        chk("k251_eop_last",  32'(b_eop_last),  32'd1);
        chk("k251_eop_cnt",   32'(b_eop_cnt),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
